// File: rtl/ex_stage_if.sv
// ex_stage_if: ID/EX operand bundle, forwarding sources, flush, EX/MEM output
// register handshake and the redirect toward fetch.
//   master: the upstream/downstream environment (drives id_*, *_fwd_*, flush, mem_ready)
//   slave : ex_stage (drives ex_ready, mem_*, redirect_*)
interface ex_stage_if;
    logic        id_valid;
    logic        ex_ready;
    logic [31:0] id_pc;
    logic [4:0]  id_rs1_addr;
    logic [4:0]  id_rs2_addr;
    logic [31:0] id_rs1_data;
    logic [31:0] id_rs2_data;
    logic [31:0] id_imm;
    logic [3:0]  id_alu_op;
    logic        id_src_a_pc;
    logic        id_src_b_imm;
    logic [4:0]  id_rd_addr;
    logic        id_rd_we;
    logic        id_is_branch;
    logic        id_is_jal;
    logic        id_is_jalr;
    logic [2:0]  id_funct3;
    logic        mem_fwd_we;
    logic [4:0]  mem_fwd_rd;
    logic [31:0] mem_fwd_data;
    logic        wb_fwd_we;
    logic [4:0]  wb_fwd_rd;
    logic [31:0] wb_fwd_data;
    logic        flush;
    logic        mem_valid;
    logic        mem_ready;
    logic [31:0] mem_result;
    logic [31:0] mem_rs2_data;
    logic [4:0]  mem_rd_addr;
    logic        mem_rd_we;
    logic [31:0] mem_pc;
    logic        redirect_valid;
    logic [31:0] redirect_pc;

    modport master (
        output id_valid, id_pc, id_rs1_addr, id_rs2_addr, id_rs1_data, id_rs2_data,
               id_imm, id_alu_op, id_src_a_pc, id_src_b_imm, id_rd_addr, id_rd_we,
               id_is_branch, id_is_jal, id_is_jalr, id_funct3,
               mem_fwd_we, mem_fwd_rd, mem_fwd_data, wb_fwd_we, wb_fwd_rd, wb_fwd_data,
               flush, mem_ready,
        input  ex_ready, mem_valid, mem_result, mem_rs2_data, mem_rd_addr, mem_rd_we,
               mem_pc, redirect_valid, redirect_pc
    );

    modport slave (
        input  id_valid, id_pc, id_rs1_addr, id_rs2_addr, id_rs1_data, id_rs2_data,
               id_imm, id_alu_op, id_src_a_pc, id_src_b_imm, id_rd_addr, id_rd_we,
               id_is_branch, id_is_jal, id_is_jalr, id_funct3,
               mem_fwd_we, mem_fwd_rd, mem_fwd_data, wb_fwd_we, wb_fwd_rd, wb_fwd_data,
               flush, mem_ready,
        output ex_ready, mem_valid, mem_result, mem_rs2_data, mem_rd_addr, mem_rd_we,
               mem_pc, redirect_valid, redirect_pc
    );
endinterface

// File: rtl/ex_stage.sv
// alu_int: RV32I integer ALU.
//   op     in  4   ADD 0000, SUB 1000, SLL 0001, SLT 0010, SLTU 0011, XOR 0100,
//                  SRL 0101, SRA 1101, OR 0110, AND 0111 (other codes give 0)
//   a, b   in  32  operands
//   result out 32
//
// ex_stage: RV32I execute stage. Forwards operands from MEM/WB, runs alu_int,
// resolves branches/jumps and registers the result into the EX/MEM output
// register behind a valid/ready handshake. A taken transfer produces a
// registered one-cycle redirect pulse.
//   clk  in  clock, rising edge
//   rst  in  asynchronous active-high reset
//   bus  slave modport of ex_stage_if (ID/EX inputs, forwarding, flush,
//        EX/MEM output register, redirect)
module alu_int (
    input  logic [3:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] result
);
    always_comb begin
        result = '0;
        case (op)
            4'b0000: result = a + b;
            4'b1000: result = a - b;
            4'b0001: result = a << b[4:0];
            4'b0010: result = {31'b0, $signed(a) < $signed(b)};
            4'b0011: result = {31'b0, a < b};
            4'b0100: result = a ^ b;
            4'b0101: result = a >> b[4:0];
            4'b1101: result = $signed(a) >>> b[4:0];
            4'b0110: result = a | b;
            4'b0111: result = a & b;
            default: result = '0;
        endcase
    end
endmodule

module ex_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input logic       clk,
    input logic       rst,
    ex_stage_if.slave bus
);
    logic [31:0] rs1_fwd, rs2_fwd, op_a, op_b, alu_res, target;
    logic        br_cond, taken, accept, load;

    logic        mem_valid_q, mem_valid_d;
    logic [31:0] mem_result_q, mem_result_d;
    logic [31:0] mem_rs2_data_q, mem_rs2_data_d;
    logic [4:0]  mem_rd_addr_q, mem_rd_addr_d;
    logic        mem_rd_we_q, mem_rd_we_d;
    logic [31:0] mem_pc_q, mem_pc_d;
    logic        redirect_valid_q, redirect_valid_d;
    logic [31:0] redirect_pc_q, redirect_pc_d;

    // MEM wins over WB; x0 is never forwarded.
    function automatic logic [31:0] fwd_sel(
        input logic [4:0]  idx,
        input logic [31:0] rf_data,
        input logic        m_we,
        input logic [4:0]  m_rd,
        input logic [31:0] m_data,
        input logic        w_we,
        input logic [4:0]  w_rd,
        input logic [31:0] w_data
    );
        if (idx != 5'd0 && m_we && m_rd == idx) begin
            return m_data;
        end else if (idx != 5'd0 && w_we && w_rd == idx) begin
            return w_data;
        end
        return rf_data;
    endfunction

    assign rs1_fwd = fwd_sel(bus.id_rs1_addr, bus.id_rs1_data, bus.mem_fwd_we, bus.mem_fwd_rd,
                             bus.mem_fwd_data, bus.wb_fwd_we, bus.wb_fwd_rd, bus.wb_fwd_data);
    assign rs2_fwd = fwd_sel(bus.id_rs2_addr, bus.id_rs2_data, bus.mem_fwd_we, bus.mem_fwd_rd,
                             bus.mem_fwd_data, bus.wb_fwd_we, bus.wb_fwd_rd, bus.wb_fwd_data);

    assign op_a = bus.id_src_a_pc  ? bus.id_pc  : rs1_fwd;
    assign op_b = bus.id_src_b_imm ? bus.id_imm : rs2_fwd;

    alu_int u_alu (
        .op     (bus.id_alu_op),
        .a      (op_a),
        .b      (op_b),
        .result (alu_res)
    );

    // Branch comparator is separate from the ALU so id_alu_op is irrelevant here.
    always_comb begin
        br_cond = 1'b0;
        case (bus.id_funct3)
            3'b000:  br_cond = rs1_fwd == rs2_fwd;
            3'b001:  br_cond = rs1_fwd != rs2_fwd;
            3'b100:  br_cond = $signed(rs1_fwd) <  $signed(rs2_fwd);
            3'b101:  br_cond = $signed(rs1_fwd) >= $signed(rs2_fwd);
            3'b110:  br_cond = rs1_fwd <  rs2_fwd;
            3'b111:  br_cond = rs1_fwd >= rs2_fwd;
            default: br_cond = 1'b0;
        endcase
    end

    assign taken  = (bus.id_is_branch && br_cond) || bus.id_is_jal || bus.id_is_jalr;
    assign target = bus.id_is_jalr ? ((rs1_fwd + bus.id_imm) & ~32'h1)
                                   : (bus.id_pc + bus.id_imm);

    assign bus.ex_ready = !mem_valid_q || bus.mem_ready;
    assign accept       = bus.id_valid && bus.ex_ready;
    // While a redirect is pending the presented instruction is wrong-path:
    // it is consumed but never loaded.
    assign load         = accept && !redirect_valid_q && !bus.flush;

    always_comb begin
        mem_valid_d      = mem_valid_q;
        mem_result_d     = mem_result_q;
        mem_rs2_data_d   = mem_rs2_data_q;
        mem_rd_addr_d    = mem_rd_addr_q;
        mem_rd_we_d      = mem_rd_we_q;
        mem_pc_d         = mem_pc_q;
        redirect_valid_d = 1'b0;
        redirect_pc_d    = redirect_pc_q;
        if (bus.flush) begin
            mem_valid_d = 1'b0;
        end else if (load) begin
            mem_valid_d    = 1'b1;
            mem_result_d   = (bus.id_is_jal || bus.id_is_jalr) ? bus.id_pc + 32'd4 : alu_res;
            mem_rs2_data_d = rs2_fwd;
            mem_rd_addr_d  = bus.id_rd_addr;
            mem_rd_we_d    = bus.id_rd_we && !bus.id_is_branch;
            mem_pc_d       = bus.id_pc;
            if (taken) begin
                redirect_valid_d = 1'b1;
                redirect_pc_d    = target;
            end
        end else if (bus.mem_ready) begin
            mem_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_valid_q      <= 1'b0;
            mem_result_q     <= '0;
            mem_rs2_data_q   <= '0;
            mem_rd_addr_q    <= '0;
            mem_rd_we_q      <= 1'b0;
            mem_pc_q         <= RESET_PC;
            redirect_valid_q <= 1'b0;
            redirect_pc_q    <= RESET_PC;
        end else begin
            mem_valid_q      <= mem_valid_d;
            mem_result_q     <= mem_result_d;
            mem_rs2_data_q   <= mem_rs2_data_d;
            mem_rd_addr_q    <= mem_rd_addr_d;
            mem_rd_we_q      <= mem_rd_we_d;
            mem_pc_q         <= mem_pc_d;
            redirect_valid_q <= redirect_valid_d;
            redirect_pc_q    <= redirect_pc_d;
        end
    end

    assign bus.mem_valid      = mem_valid_q;
    assign bus.mem_result     = mem_result_q;
    assign bus.mem_rs2_data   = mem_rs2_data_q;
    assign bus.mem_rd_addr    = mem_rd_addr_q;
    assign bus.mem_rd_we      = mem_rd_we_q;
    assign bus.mem_pc         = mem_pc_q;
    assign bus.redirect_valid = redirect_valid_q;
    assign bus.redirect_pc    = redirect_pc_q;
endmodule

// File: tb/tb_ex_stage.sv
// Self-checking bench for ex_stage: a behavioural model of the output register
// and redirect, compared every cycle, plus directed literal expectations.
module tb_ex_stage;
    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   failures = 0;
    logic cmp_en = 1'b0;

    ex_stage_if bus();

    ex_stage #(.RESET_PC(32'h0000_0000)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Model state: what the registered outputs must hold.
    logic        m_valid = 1'b0;
    logic [31:0] m_result = '0, m_rs2 = '0, m_pc = '0, m_rpc = '0;
    logic [4:0]  m_rd = '0;
    logic        m_we = 1'b0, m_rv = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] fwd(input logic [4:0] idx, input logic [31:0] rf);
        if (idx == 5'd0) return rf;
        if (bus.mem_fwd_we && bus.mem_fwd_rd == idx) return bus.mem_fwd_data;
        if (bus.wb_fwd_we && bus.wb_fwd_rd == idx) return bus.wb_fwd_data;
        return rf;
    endfunction

    function automatic logic [31:0] alu(input logic [3:0] op, input logic [31:0] a,
                                        input logic [31:0] b);
        int sh;
        sh = int'(b % 32);
        case (op)
            4'b0000: return a + b;
            4'b1000: return a - b;
            4'b0001: return a << sh;
            4'b0010: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'b0011: return (a < b) ? 32'd1 : 32'd0;
            4'b0100: return a ^ b;
            4'b0101: return a >> sh;
            4'b1101: return $signed(a) >>> sh;
            4'b0110: return a | b;
            4'b0111: return a & b;
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic cond(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        case (f)
            3'd0: return a == b;
            3'd1: return a != b;
            3'd4: return $signed(a) < $signed(b);
            3'd5: return $signed(a) >= $signed(b);
            3'd6: return a < b;
            3'd7: return a >= b;
            default: return 1'b0;
        endcase
    endfunction

    always @(posedge clk or posedge rst) begin : model
        logic [31:0] a1, a2, opa, opb;
        logic        acc, tk, jump;
        if (rst) begin
            m_valid <= 1'b0; m_result <= '0; m_rs2 <= '0; m_rd <= '0;
            m_we <= 1'b0; m_pc <= '0; m_rv <= 1'b0; m_rpc <= '0;
        end else begin
            acc  = bus.id_valid && (!m_valid || bus.mem_ready);
            a1   = fwd(bus.id_rs1_addr, bus.id_rs1_data);
            a2   = fwd(bus.id_rs2_addr, bus.id_rs2_data);
            opa  = bus.id_src_a_pc ? bus.id_pc : a1;
            opb  = bus.id_src_b_imm ? bus.id_imm : a2;
            jump = bus.id_is_jal || bus.id_is_jalr;
            tk   = jump || (bus.id_is_branch && cond(bus.id_funct3, a1, a2));
            m_rv <= 1'b0;
            if (bus.flush) begin
                m_valid <= 1'b0;
            end else if (acc && !m_rv) begin
                m_valid  <= 1'b1;
                m_result <= jump ? bus.id_pc + 32'd4 : alu(bus.id_alu_op, opa, opb);
                m_rs2    <= a2;
                m_rd     <= bus.id_rd_addr;
                m_we     <= bus.id_rd_we && !bus.id_is_branch;
                m_pc     <= bus.id_pc;
                if (tk) begin
                    m_rv  <= 1'b1;
                    m_rpc <= bus.id_is_jalr ? ((a1 + bus.id_imm) & 32'hFFFF_FFFE)
                                            : bus.id_pc + bus.id_imm;
                end
            end else if (bus.mem_ready) begin
                m_valid <= 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("ex_ready", {31'b0, bus.ex_ready}, {31'b0, !m_valid || bus.mem_ready});
            chk("mem_valid", {31'b0, bus.mem_valid}, {31'b0, m_valid});
            chk("mem_result", bus.mem_result, m_result);
            chk("mem_rs2_data", bus.mem_rs2_data, m_rs2);
            chk("mem_rd_addr", {27'b0, bus.mem_rd_addr}, {27'b0, m_rd});
            chk("mem_rd_we", {31'b0, bus.mem_rd_we}, {31'b0, m_we});
            chk("mem_pc", bus.mem_pc, m_pc);
            chk("redirect_valid", {31'b0, bus.redirect_valid}, {31'b0, m_rv});
            chk("redirect_pc", bus.redirect_pc, m_rpc);
        end
    end

    task automatic clear_in();
        bus.id_valid = 0; bus.id_pc = '0; bus.id_rs1_addr = '0; bus.id_rs2_addr = '0;
        bus.id_rs1_data = '0; bus.id_rs2_data = '0; bus.id_imm = '0; bus.id_alu_op = '0;
        bus.id_src_a_pc = 0; bus.id_src_b_imm = 0; bus.id_rd_addr = '0; bus.id_rd_we = 0;
        bus.id_is_branch = 0; bus.id_is_jal = 0; bus.id_is_jalr = 0; bus.id_funct3 = '0;
        bus.mem_fwd_we = 0; bus.mem_fwd_rd = '0; bus.mem_fwd_data = '0;
        bus.wb_fwd_we = 0; bus.wb_fwd_rd = '0; bus.wb_fwd_data = '0;
        bus.flush = 0; bus.mem_ready = 1;
    endtask

    task automatic instr(input logic [31:0] pc, input logic [4:0] r1, input logic [31:0] d1,
                         input logic [4:0] r2, input logic [31:0] d2, input logic [31:0] imm,
                         input logic [3:0] op, input logic bimm, input logic [4:0] rd);
        bus.id_valid = 1; bus.id_pc = pc; bus.id_rs1_addr = r1; bus.id_rs1_data = d1;
        bus.id_rs2_addr = r2; bus.id_rs2_data = d2; bus.id_imm = imm; bus.id_alu_op = op;
        bus.id_src_b_imm = bimm; bus.id_rd_addr = rd; bus.id_rd_we = 1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [3:0] ops [10] = '{4'b0000, 4'b1000, 4'b0001, 4'b0010, 4'b0011,
                             4'b0100, 4'b0101, 4'b1101, 4'b0110, 4'b0111};

    initial begin
        rst = 1'b1;
        clear_in();
        repeat (2) @(posedge clk);
        #1;
        chk("rst mem_valid", {31'b0, bus.mem_valid}, 32'd0);
        chk("rst redirect_valid", {31'b0, bus.redirect_valid}, 32'd0);
        chk("rst mem_pc", bus.mem_pc, 32'd0);
        chk("rst mem_result", bus.mem_result, 32'd0);
        rst = 1'b0;
        cmp_en = 1'b1;

        // ADDI x3 = 5 + 7
        instr(32'h10, 5'd1, 32'd5, 5'd0, 32'd0, 32'd7, 4'b0000, 1'b1, 5'd3);
        tick();
        chk("addi valid", {31'b0, bus.mem_valid}, 32'd1);
        chk("addi result", bus.mem_result, 32'd12);
        chk("addi rd", {27'b0, bus.mem_rd_addr}, 32'd3);
        chk("addi we", {31'b0, bus.mem_rd_we}, 32'd1);

        // Forward priority: MEM over WB
        clear_in();
        instr(32'h14, 5'd4, 32'h99, 5'd5, 32'd1, 32'd0, 4'b0000, 1'b0, 5'd6);
        bus.mem_fwd_we = 1; bus.mem_fwd_rd = 5'd4; bus.mem_fwd_data = 32'h10;
        bus.wb_fwd_we = 1;  bus.wb_fwd_rd = 5'd4;  bus.wb_fwd_data = 32'h20;
        tick();
        chk("fwd mem prio", bus.mem_result, 32'h11);
        bus.mem_fwd_we = 0;
        tick();
        chk("fwd wb", bus.mem_result, 32'h21);
        bus.mem_fwd_we = 1; bus.id_rs1_addr = 5'd0; bus.mem_fwd_rd = 5'd0; bus.wb_fwd_rd = 5'd0;
        tick();
        chk("fwd x0", bus.mem_result, 32'h9a);

        // BLT taken (-1 < 1), then BLTU not taken
        clear_in();
        instr(32'h100, 5'd1, 32'hFFFF_FFFF, 5'd2, 32'd1, 32'h20, 4'b0000, 1'b0, 5'd7);
        bus.id_is_branch = 1; bus.id_funct3 = 3'b100;
        tick();
        chk("blt redirect", {31'b0, bus.redirect_valid}, 32'd1);
        chk("blt target", bus.redirect_pc, 32'h120);
        chk("blt rd_we", {31'b0, bus.mem_rd_we}, 32'd0);
        bus.id_valid = 0;
        tick();
        chk("blt pulse end", {31'b0, bus.redirect_valid}, 32'd0);
        bus.id_valid = 1; bus.id_funct3 = 3'b110;
        tick();
        chk("bltu no redirect", {31'b0, bus.redirect_valid}, 32'd0);
        chk("bltu valid", {31'b0, bus.mem_valid}, 32'd1);

        // JALR then shadowed instruction
        clear_in();
        instr(32'h200, 5'd1, 32'h1003, 5'd0, 32'd0, 32'd0, 4'b0000, 1'b1, 5'd1);
        bus.id_is_jalr = 1;
        tick();
        chk("jalr target", bus.redirect_pc, 32'h1002);
        chk("jalr result", bus.mem_result, 32'h204);
        clear_in();
        instr(32'h204, 5'd0, 32'd0, 5'd0, 32'd0, 32'd1, 4'b0000, 1'b1, 5'd9);
        tick();
        chk("shadow dropped", {31'b0, bus.mem_valid}, 32'd0);

        // JAL with wrapping PC
        clear_in();
        instr(32'hFFFF_FFFC, 5'd0, 32'd0, 5'd0, 32'd0, 32'd8, 4'b0000, 1'b1, 5'd1);
        bus.id_is_jal = 1;
        tick();
        chk("jal wrap result", bus.mem_result, 32'd0);
        chk("jal wrap target", bus.redirect_pc, 32'd4);
        clear_in();
        tick();

        // Backpressure
        instr(32'h300, 5'd0, 32'd0, 5'd0, 32'd0, 32'd100, 4'b0000, 1'b1, 5'd10);
        tick();
        bus.mem_ready = 0;
        bus.id_pc = 32'h304; bus.id_imm = 32'd101; bus.id_rd_addr = 5'd11;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("stall ex_ready", {31'b0, bus.ex_ready}, 32'd0);
            chk("stall hold", bus.mem_result, 32'd100);
        end
        bus.mem_ready = 1;
        tick();
        chk("release B", bus.mem_result, 32'd101);
        bus.id_pc = 32'h308; bus.id_imm = 32'd102; bus.id_rd_addr = 5'd12;
        tick();
        chk("release C", bus.mem_result, 32'd102);

        // Flush with a taken branch presented
        clear_in();
        instr(32'h400, 5'd1, 32'd5, 5'd2, 32'd5, 32'h40, 4'b0000, 1'b0, 5'd0);
        bus.id_is_branch = 1; bus.id_funct3 = 3'b000; bus.flush = 1;
        tick();
        chk("flush redirect", {31'b0, bus.redirect_valid}, 32'd0);
        chk("flush valid", {31'b0, bus.mem_valid}, 32'd0);

        // Mixed random traffic against the model
        for (int i = 0; i < 40; i++) begin
            clear_in();
            instr($urandom, 5'($urandom_range(0, 7)), $urandom, 5'($urandom_range(0, 7)),
                  (i % 3 == 0) ? bus.id_rs1_data : $urandom, $urandom,
                  ops[$urandom_range(0, 9)], 1'($urandom), 5'($urandom));
            bus.id_valid = ($urandom_range(0, 4) != 0);
            bus.id_src_a_pc = ($urandom_range(0, 5) == 0);
            bus.id_rd_we = 1'($urandom);
            bus.id_funct3 = 3'($urandom);
            case ($urandom_range(0, 5))
                0: bus.id_is_branch = 1;
                1: bus.id_is_jal = 1;
                2: bus.id_is_jalr = 1;
                default: ;
            endcase
            bus.mem_fwd_we = 1'($urandom); bus.mem_fwd_rd = 5'($urandom_range(0, 7));
            bus.mem_fwd_data = $urandom;
            bus.wb_fwd_we = 1'($urandom); bus.wb_fwd_rd = 5'($urandom_range(0, 7));
            bus.wb_fwd_data = $urandom;
            bus.mem_ready = ($urandom_range(0, 3) != 0);
            bus.flush = (i % 9 == 8);
            tick();
        end

        // Reset asserted mid-stall
        clear_in();
        instr(32'h500, 5'd0, 32'd0, 5'd0, 32'd0, 32'd55, 4'b0000, 1'b1, 5'd13);
        tick();
        clear_in();
        bus.mem_ready = 0;
        tick();
        chk("pre-reset held", bus.mem_result, 32'd55);
        #2 rst = 1'b1;
        #1;
        chk("async rst valid", {31'b0, bus.mem_valid}, 32'd0);
        chk("async rst result", bus.mem_result, 32'd0);
        chk("async rst rd_we", {31'b0, bus.mem_rd_we}, 32'd0);
        chk("async rst pc", bus.mem_pc, 32'd0);
        tick();
        rst = 1'b0;
        bus.mem_ready = 1;
        repeat (2) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/ex_stage.md
# ex_stage

Execute stage of the RV32I pipeline: takes decoded operands from the ID/EX boundary, resolves register forwarding, drives the `alu_int` integer ALU, resolves branches and jumps, and holds the result in the EX/MEM output register behind a valid/ready handshake. A taken control transfer produces a one-cycle redirect pulse toward fetch.

## Interface
Parameters:
- `RESET_PC`, 32'h0000_0000, value of `mem_pc` and `redirect_pc` at reset.

Ports:
- `clk`  in  1  clock; all state changes on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `id_valid`  in  1  ID/EX holds a valid instruction.
- `ex_ready`  out  1  this stage accepts the instruction this cycle.
- `id_pc`  in  32  instruction PC.
- `id_rs1_addr`, `id_rs2_addr`  in  5 each  source register indices.
- `id_rs1_data`, `id_rs2_data`  in  32 each  register-file read data.
- `id_imm`  in  32  sign-extended immediate.
- `id_alu_op`  in  4  `alu_int` opcode: ADD 0000, SUB 1000, SLL 0001, SLT 0010, SLTU 0011, XOR 0100, SRL 0101, SRA 1101, OR 0110, AND 0111.
- `id_src_a_pc`  in  1  operand A = `id_pc`, not rs1 (AUIPC).
- `id_src_b_imm`  in  1  operand B = `id_imm`, not rs2.
- `id_rd_addr`  in  5  destination index.
- `id_rd_we`  in  1  instruction writes rd.
- `id_is_branch`, `id_is_jal`, `id_is_jalr`  in  1 each  control-transfer class; at most one set.
- `id_funct3`  in  3  branch condition.
- `mem_fwd_we`, `mem_fwd_rd`(5), `mem_fwd_data`(32)  in  forwarding source from MEM.
- `wb_fwd_we`, `wb_fwd_rd`(5), `wb_fwd_data`(32)  in  forwarding source from WB.
- `flush`  in  1  kill the instruction held and the one presented.
- `mem_valid`  out  1  output register valid.
- `mem_ready`  in  1  MEM accepts the output register.
- `mem_result`  out  32  ALU result, or PC+4 for JAL/JALR.
- `mem_rs2_data`  out  32  forwarded rs2, used as store data.
- `mem_rd_addr`  out  5; `mem_rd_we`  out  1; `mem_pc`  out  32.
- `redirect_valid`  out  1  one-cycle pulse for a taken branch or jump.
- `redirect_pc`  out  32  target address.

## Operation
- Forwarding, per source operand: if `mem_fwd_we` and `mem_fwd_rd` equals the index and the index is non-zero, use `mem_fwd_data`. Otherwise, if the WB fields match under the same condition, use `wb_fwd_data`. Otherwise use the register-file data. MEM takes priority over WB. x0 is never forwarded.
- Operand A = `id_pc` if `id_src_a_pc`, else forwarded rs1. Operand B = `id_imm` if `id_src_b_imm`, else forwarded rs2. Both go to an `alu_int` instance.
- Branch compare uses forwarded rs1 and rs2 and its own comparator, independent of `id_alu_op`. funct3 encoding: 000 EQ, 001 NE, 100 LT signed, 101 GE signed, 110 LTU, 111 GEU. Codes 010 and 011 are not taken.
- Targets:
  - branch: `id_pc + id_imm`
  - JAL: `id_pc + id_imm`
  - JALR: `(rs1 + id_imm) & ~32'h1`
  - All sums wrap modulo 2^32. No misalignment check.
- Result: JAL and JALR write `id_pc + 4` (wraps). All other instructions write the ALU result. A branch forces `mem_rd_we = 0`.
- Handshake: `ex_ready = !mem_valid || mem_ready`. The instruction is accepted when `id_valid && ex_ready`.
- Output register load:
  - Accept and not shadowed: load all `mem_*` fields and set `mem_valid`.
  - Else if `mem_ready`: clear `mem_valid`.
  - Else: hold.
- Shadow: during the cycle `redirect_valid` is high, an accepted instruction is wrong-path. It is consumed (`ex_ready` still follows the rule above) and dropped: it does not load, and `mem_valid` clears if `mem_ready`.
- Flush: has priority over everything. `mem_valid` clears and `redirect_valid` clears at the next edge. The instruction presented in the flush cycle is dropped.
- `redirect_valid`/`redirect_pc` are registered. They are set for exactly one cycle after a non-shadowed, non-flushed accept of a taken branch, JAL or JALR, and clear the following cycle even if MEM stalls.

## Timing
- Latency: one cycle from accept to `mem_valid` and `redirect_valid`.
- Throughput: one instruction per cycle while `mem_ready` is high.
- Stall: while `mem_valid && !mem_ready`, all `mem_*` outputs hold and `ex_ready` is 0.
- Reset, asynchronous:
  - `mem_valid`, `redirect_valid`, `mem_rd_we` = 0
  - `mem_result`, `mem_rs2_data`, `mem_rd_addr` = 0
  - `mem_pc`, `redirect_pc` = `RESET_PC`
- Reset asserted mid-stall discards the held instruction.
- Forwarding and operand selection are combinational within the accept cycle. The forwarding inputs must be valid in that cycle.

## Test plan
- ADDI: rs1_data=5, imm=7, alu_op 0000, src_b_imm, rd=3 -> next cycle `mem_valid`=1, `mem_result`=12, `mem_rd_addr`=3, `mem_rd_we`=1.
- Forward priority: rs1=4, both `mem_fwd_rd` and `wb_fwd_rd`=4 with data 0x10 and 0x20, rs2_data=1, ADD -> result 0x11. Repeat with rs1=0 -> register-file data used.
- BLT: rs1=0xFFFF_FFFF, rs2=1, pc=0x100, imm=0x20 -> `redirect_valid` pulses one cycle, `redirect_pc`=0x120, `mem_rd_we`=0. Same operands with BLTU -> no redirect.
- JALR: pc=0x200, rs1=0x1003, imm=0 -> `redirect_pc`=0x1002, `mem_result`=0x204. The instruction accepted in the following cycle is dropped.
- Backpressure: `mem_ready`=0 for 3 cycles with valid input -> `ex_ready`=0 and outputs hold. Release -> back-to-back results in order.
- Flush and reset: flush in the cycle a taken branch is presented -> no redirect, `mem_valid`=0. `rst` asserted during a stall -> all outputs at reset values immediately.
